// File: rtl/marquee_scroll_ctrl.sv
// Scrolling-marquee sequencer: message buffer, step prescaler, character ROM
// addressing and a four-digit shift chain (led_a leftmost, new glyphs enter at led_d).
module marquee_scroll_ctrl #(
  parameter int unsigned TICK_DIV  = 4194304,
  parameter int unsigned MSG_DEPTH = 32,
  parameter logic [15:0] BLANK_SEG = 16'hFFFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic                         loop,
  input  logic                         msg_we,
  input  logic [$clog2(MSG_DEPTH)-1:0] msg_waddr,
  input  logic [7:0]                   msg_wdata,
  input  logic [$clog2(MSG_DEPTH):0]   msg_len,
  output logic [7:0]                   rom_ascii,
  input  logic [15:0]                  rom_segments,
  output logic [15:0]                  led_a,
  output logic [15:0]                  led_b,
  output logic [15:0]                  led_c,
  output logic [15:0]                  led_d,
  output logic [$clog2(MSG_DEPTH)-1:0] char_idx,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int unsigned AW = $clog2(MSG_DEPTH);
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(MSG_DEPTH);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT, FETCH, LOOKUP, SHIFT, DONE} state_t;

  state_t        state;
  logic [7:0]    msg_buf [MSG_DEPTH];
  logic [PW-1:0] presc;
  logic [AW:0]   len_q;
  logic [AW:0]   fetch_cnt;
  logic [2:0]    pad;
  logic          pad_step;
  logic [15:0]   glyph;
  logic [AW:0]   len_clamped;

  // fetch_cnt is one bit wider than the buffer index so a full-depth message
  // terminates instead of wrapping back to index 0
  assign char_idx    = fetch_cnt[AW-1:0];
  assign len_clamped = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;

  always_ff @(posedge clk) begin
    if (msg_we) msg_buf[msg_waddr] <= msg_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      presc      <= '0;
      len_q      <= '0;
      fetch_cnt  <= '0;
      pad        <= '0;
      pad_step   <= 1'b0;
      glyph      <= BLANK_SEG;
      rom_ascii  <= 8'h20;
      led_a      <= BLANK_SEG;
      led_b      <= BLANK_SEG;
      led_c      <= BLANK_SEG;
      led_d      <= BLANK_SEG;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // free-running through FETCH..DONE keeps the step period at TICK_DIV
      presc <= (presc == TICK_LAST) ? '0 : presc + PW'(1);
      unique case (state)
        IDLE: begin
          if (run && msg_len != '0) begin
            len_q     <= len_clamped;
            fetch_cnt <= '0;
            pad       <= '0;
            busy      <= 1'b1;
            state     <= CLEAR;
          end else begin
            busy <= 1'b0;
          end
        end
        CLEAR: begin
          led_a <= BLANK_SEG;
          led_b <= BLANK_SEG;
          led_c <= BLANK_SEG;
          led_d <= BLANK_SEG;
          presc <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (!run) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (presc == TICK_LAST) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          if (fetch_cnt < len_q) begin
            rom_ascii <= msg_buf[char_idx];
            fetch_cnt <= fetch_cnt + (AW + 1)'(1);
            pad_step  <= 1'b0;
          end else begin
            rom_ascii <= 8'h20;
            pad       <= pad + 3'd1;
            pad_step  <= 1'b1;
          end
          state <= LOOKUP;
        end
        LOOKUP: begin
          glyph <= pad_step ? BLANK_SEG : rom_segments;
          state <= SHIFT;
        end
        SHIFT: begin
          led_a <= led_b;
          led_b <= led_c;
          led_c <= led_d;
          led_d <= glyph;
          if (pad == 3'd4) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        DONE: begin
          if (loop && run && msg_len != '0) begin
            len_q     <= len_clamped;
            fetch_cnt <= '0;
            pad       <= '0;
            // with the minimum TICK_DIV the DONE cycle is itself a tick cycle
            state     <= (presc == TICK_LAST) ? FETCH : WAIT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/marquee_scroll_ctrl.md
Name: marquee_scroll_ctrl

Overview:
- Sequencer for the 4-digit 16-segment scrolling marquee.
- Holds a loadable ASCII message buffer and paces scrolling with a clock prescaler.
- Drives the shared character ROM (ascii in, segments out, combinational) and shifts each looked-up glyph into a 4-deep display register chain: a <- b <- c <- d <- new.
- Sits between the host/top level and the LED segment pins; replaces hard-coded per-step glyph tables.

Parameters:
- TICK_DIV, 4194304, clk cycles per scroll step (>=4); prescaler width = clog2(TICK_DIV).
- MSG_DEPTH, 32, message buffer entries (power of 2).
- BLANK_SEG, 16'hFFFF, glyph for an unlit digit (segments active-low).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = scroll enabled
- loop  in  1  level; 1 = restart the message after the scroll-off
- msg_we  in  1  message buffer write strobe
- msg_waddr  in  5  write address (clog2(MSG_DEPTH))
- msg_wdata  in  8  ASCII byte to write
- msg_len  in  6  message length, 0..MSG_DEPTH; sampled at start only
- rom_ascii  out  8  registered address to the character ROM
- rom_segments  in  16  ROM glyph; combinational from rom_ascii
- led_a, led_b, led_c, led_d  out  16 each  digit registers; led_a is leftmost
- char_idx  out  5  index of the next character to fetch
- busy  out  1  high from start until return to IDLE
- frame_done  out  1  one-cycle pulse after the last blank shift of a pass

Behaviour:
- Reset (async, rst=1): led_a..led_d = BLANK_SEG, rom_ascii = 8'h20, char_idx = 0, prescaler = 0, busy = 0, frame_done = 0, FSM = IDLE, pad count = 0, latched length = 0.
- Message buffer:
  - Synchronous write when msg_we=1; always permitted, including while busy.
  - A written byte takes effect when its index is next fetched. Contents are not cleared by rst.
- FSM states: IDLE, CLEAR, WAIT, FETCH, LOOKUP, SHIFT, DONE.
- IDLE:
  - If run=1 and msg_len!=0: latch msg_len, char_idx=0, pad=0 -> CLEAR.
  - If msg_len==0: stay in IDLE, busy=0, displays unchanged.
- CLEAR: all four led_* = BLANK_SEG, prescaler = 0, busy = 1 -> WAIT.
- WAIT:
  - Prescaler increments each cycle.
  - At prescaler == TICK_DIV-1 (the tick cycle N): prescaler wraps to 0 -> FETCH.
- FETCH (cycle N+1):
  - If char_idx < latched length: rom_ascii <= buf[char_idx], char_idx++.
  - Otherwise (padding): rom_ascii <= 8'h20, pad++.
- LOOKUP (cycle N+2):
  - Register rom_segments into the glyph register; padding steps use BLANK_SEG and ignore the ROM.
- SHIFT (cycle N+3): led_a<=led_b, led_b<=led_c, led_c<=led_d, led_d<=glyph.
  - New digits are visible from N+4, so the fixed latency is tick + 4.
  - Next state: if pad == 4, go to DONE; otherwise go to WAIT.
- Prescaler runs continuously through FETCH/LOOKUP/SHIFT, so the step period is exactly TICK_DIV cycles.
- DONE: frame_done = 1 for one cycle.
  - If loop=1 and run=1: char_idx=0, pad=0, re-latch msg_len -> WAIT. Displays are not cleared; the text re-enters from the right after the blanks.
  - Else if loop=1, run=1 and the new msg_len==0: go to IDLE.
  - Else: go to IDLE, busy=0.
- One pass = latched length + 4 shifts.
- run deasserted mid-pass:
  - The step in flight (FETCH..SHIFT) completes.
  - At the next WAIT entry the FSM goes to IDLE, busy=0, displays frozen, char_idx held.
  - The next start restarts from CLEAR.
- rst mid-operation: immediate return to reset values, including blank displays.
- Width rules: char_idx wraps modulo MSG_DEPTH and is never compared beyond the latched length. msg_len > MSG_DEPTH is clamped to MSG_DEPTH at latch.
- Simultaneous events:
  - msg_we to an index in the same cycle as its FETCH: FETCH reads the old byte.
  - run falling in the DONE cycle: go to IDLE (no loop).

Test Plan:
- TICK_DIV=8, buffer "AB", msg_len=2, run=1, loop=0 -> 6 shifts at 8-cycle spacing; led_d shows seg('A') then seg('B'); after the 6th shift all led_* = FFFF; one frame_done pulse; busy falls next cycle.
- Latency: record the tick cycle N of the first step -> rom_ascii=0x41 at N+1; led_d changes exactly at N+4; led_a..led_c = FFFF.
- msg_len=5 "HELLO", loop=1 -> after frame_done, the next shift into led_d is seg('H'); char_idx resets to 0; busy stays 1; run=0 -> busy=0 within TICK_DIV+4 cycles, displays frozen.
- msg_len=0, run=1 -> busy stays 0, rom_ascii stays 0x20, no led change for 100 cycles.
- rst pulse mid-LOOKUP with led_d=seg('C') -> led_* = FFFF asynchronously, busy=0, char_idx=0; restart produces the full sequence from index 0.
- msg_we to index 3 ('Z') while scrolling index 1 of "ABCD" -> the 4th shifted glyph is seg('Z'); a write to index 3 in its own FETCH cycle yields seg('D').
